// File: rtl/vga_pkg.sv
// Shared VGA 640x480@60 timing constants, counter widths and sync-bundle type,
// reused by the timing generator, pixel sources and benches.
package vga_pkg;

  localparam int H_ACTIVE   = 640;
  localparam int H_FP       = 16;
  localparam int H_SYNC     = 96;
  localparam int H_BP       = 48;
  localparam int V_ACTIVE   = 480;
  localparam int V_FP       = 10;
  localparam int V_SYNC     = 2;
  localparam int V_BP       = 33;
  localparam int PRINT_LINE = 522;

  localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;

  localparam int CNT_W       = 10;
  localparam int FRAME_W     = 16;
  localparam int RGB_W       = 24;
  localparam int SYNC_STAGES = 2;

  typedef logic [CNT_W-1:0] cnt_t;

  // Sync/blank bundle carried down the output pipeline; polarity as seen on pins.
  typedef struct packed {
    logic hs_n;
    logic vs_n;
    logic blank_n;
  } sync_t;

  localparam sync_t SYNC_IDLE = '{hs_n: 1'b1, vs_n: 1'b1, blank_n: 1'b0};

  function automatic logic in_window(input int val, input int lo, input int len);
    return (val >= lo) && (val < lo + len);
  endfunction

endpackage

// File: rtl/vga_counter.sv
// Free-running horizontal/vertical raster counters with wrap strobes.
module vga_counter
  import vga_pkg::*;
#(
  parameter int H_TOT = H_TOTAL,
  parameter int V_TOT = V_TOTAL
) (
  input  logic clk_i,
  input  logic rst_n_i,
  output cnt_t h_o,
  output cnt_t v_o,
  output cnt_t v_nxt_o,
  output logic h_wrap_o,
  output logic frame_wrap_o
);

  cnt_t h_q, h_d;
  cnt_t v_q, v_d;
  logic h_last, v_last;

  always_comb begin
    h_last = (h_q == cnt_t'(H_TOT - 1));
    v_last = (v_q == cnt_t'(V_TOT - 1));
    h_d    = h_last ? '0 : h_q + 1'b1;
    v_d    = v_q;
    if (h_last) v_d = v_last ? '0 : v_q + 1'b1;
  end

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      h_q <= '0;
      v_q <= '0;
    end else begin
      h_q <= h_d;
      v_q <= v_d;
    end
  end

  assign h_o          = h_q;
  assign v_o          = v_q;
  assign v_nxt_o      = v_d;
  assign h_wrap_o     = h_last;
  assign frame_wrap_o = h_last & v_last;

endmodule

// File: rtl/vga_timing_gen.sv
// VGA timing generator: raster request to a 1-cycle-latency pixel source,
// sync/blank decode aligned to registered RGB, frame-capture strobe and frame count.
module vga_timing_gen #(
  parameter int H_ACTIVE   = vga_pkg::H_ACTIVE,
  parameter int H_FP       = vga_pkg::H_FP,
  parameter int H_SYNC     = vga_pkg::H_SYNC,
  parameter int H_BP       = vga_pkg::H_BP,
  parameter int V_ACTIVE   = vga_pkg::V_ACTIVE,
  parameter int V_FP       = vga_pkg::V_FP,
  parameter int V_SYNC     = vga_pkg::V_SYNC,
  parameter int V_BP       = vga_pkg::V_BP,
  parameter int PRINT_LINE = vga_pkg::PRINT_LINE
) (
  input  logic        CLOCK_25,
  input  logic        RESET_N,
  input  logic [23:0] PIX_RGB,
  output logic [9:0]  PIX_X,
  output logic [9:0]  PIX_Y,
  output logic        PIX_REQ,
  output logic        VGA_CLK,
  output logic        VGA_HS,
  output logic        VGA_VS,
  output logic        VGA_BLANK_N,
  output logic [7:0]  VGA_R,
  output logic [7:0]  VGA_G,
  output logic [7:0]  VGA_B,
  output logic        PRINT,
  output logic [15:0] FRAME_CNT
);
  import vga_pkg::*;

  localparam int H_TOT = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int V_TOT = V_ACTIVE + V_FP + V_SYNC + V_BP;
  localparam int HS_LO = H_ACTIVE + H_FP;
  localparam int VS_LO = V_ACTIVE + V_FP;

  cnt_t h, v, v_nxt;
  logic h_wrap, frame_wrap;

  vga_counter #(
    .H_TOT (H_TOT),
    .V_TOT (V_TOT)
  ) u_cnt (
    .clk_i        (CLOCK_25),
    .rst_n_i      (RESET_N),
    .h_o          (h),
    .v_o          (v),
    .v_nxt_o      (v_nxt),
    .h_wrap_o     (h_wrap),
    .frame_wrap_o (frame_wrap)
  );

  logic  pix_req;
  sync_t sync_now;

  always_comb begin
    pix_req          = (int'(h) < H_ACTIVE) && (int'(v) < V_ACTIVE);
    sync_now.hs_n    = !in_window(int'(h), HS_LO, H_SYNC);
    sync_now.vs_n    = !in_window(int'(v), VS_LO, V_SYNC);
    sync_now.blank_n = pix_req;
  end

  assign PIX_REQ = pix_req;
  assign PIX_X   = pix_req ? h : '0;
  assign PIX_Y   = pix_req ? v : '0;

  // Stage 1 blank_n is the request the pixel source is answering this cycle,
  // so it gates RGB capture; the last stage lines up with the RGB register.
  sync_t [SYNC_STAGES:1] sync_pipe_q, sync_pipe_d;
  logic  [RGB_W-1:0]     rgb_q, rgb_d;
  logic                  print_q, print_d;
  logic  [FRAME_W-1:0]   frame_q, frame_d;

  always_comb begin
    sync_pipe_d = {sync_pipe_q[SYNC_STAGES-1:1], sync_now};
    rgb_d       = sync_pipe_q[1].blank_n ? PIX_RGB : '0;
    // PRINT covers the whole of PRINT_LINE, so it only changes at a line boundary.
    print_d     = h_wrap ? (int'(v_nxt) == PRINT_LINE) : print_q;
    frame_d     = frame_wrap ? frame_q + 1'b1 : frame_q;
  end

  always_ff @(posedge CLOCK_25 or negedge RESET_N) begin
    if (!RESET_N) begin
      sync_pipe_q <= {SYNC_STAGES{SYNC_IDLE}};
      rgb_q       <= '0;
      print_q     <= 1'b0;
      frame_q     <= '0;
    end else begin
      sync_pipe_q <= sync_pipe_d;
      rgb_q       <= rgb_d;
      print_q     <= print_d;
      frame_q     <= frame_d;
    end
  end

  assign VGA_CLK     = CLOCK_25;
  assign VGA_HS      = sync_pipe_q[SYNC_STAGES].hs_n;
  assign VGA_VS      = sync_pipe_q[SYNC_STAGES].vs_n;
  assign VGA_BLANK_N = sync_pipe_q[SYNC_STAGES].blank_n;
  assign VGA_R       = rgb_q[23:16];
  assign VGA_G       = rgb_q[15:8];
  assign VGA_B       = rgb_q[7:0];
  assign PRINT       = print_q;
  assign FRAME_CNT   = frame_q;

endmodule

// File: doc/vga_timing_gen.md
VGA_TIMING_GEN -- requirements
Module: vga_timing_gen

Interface
REQ-001 Parameters SHALL be (name, default, meaning): H_ACTIVE 640 visible pixels; H_FP 16 front porch; H_SYNC 96 sync width; H_BP 48 back porch; V_ACTIVE 480 visible lines; V_FP 10; V_SYNC 2; V_BP 33; PRINT_LINE 522 line whose duration PRINT is held high.
REQ-002 Ports SHALL be (name, direction, width, meaning):
- CLOCK_25, in, 1, pixel clock, sole clock.
- RESET_N, in, 1, asynchronous active-low reset.
- PIX_RGB, in, 24, {R,G,B} from pixel source, one cycle after PIX_X/PIX_Y.
- PIX_X, out, 10, requested column.
- PIX_Y, out, 10, requested line.
- PIX_REQ, out, 1, request valid.
- VGA_CLK, out, 1, pixel clock to DAC.
- VGA_HS, out, 1, horizontal sync, active low.
- VGA_VS, out, 1, vertical sync, active low.
- VGA_BLANK_N, out, 1, high while active video.
- VGA_R, out, 8, red.
- VGA_G, out, 8, green.
- VGA_B, out, 8, blue.
- PRINT, out, 1, frame-capture strobe.
- FRAME_CNT, out, 16, completed-frame count.

Function
REQ-003 H counter SHALL count 0..H_TOTAL-1 (H_TOTAL = sum of H parameters, 800) every clock and wrap to 0.
REQ-004 V counter SHALL advance only on H wrap, count 0..V_TOTAL-1 (525) and wrap to 0.
REQ-005 PIX_REQ SHALL be combinational, high iff h < H_ACTIVE and v < V_ACTIVE; PIX_X=h and PIX_Y=v when high, 0 otherwise.
REQ-006 Pixel source latency SHALL be exactly 1 cycle; the block SHALL register PIX_RGB into VGA_R/G/B, forcing 0 when the delayed PIX_REQ is low.
REQ-007 HS, VS and BLANK_N SHALL be decoded from the counters and delayed through a 2-stage register pipeline so they align with VGA_R/G/B (total latency 2 cycles counter-to-pin).
REQ-008 Undelayed HS SHALL be low for H_ACTIVE+H_FP <= h < H_ACTIVE+H_FP+H_SYNC (656..751); VS SHALL be low for V_ACTIVE+V_FP <= v < V_ACTIVE+V_FP+V_SYNC (490..491).
REQ-009 VGA_BLANK_N SHALL equal the 2-cycle-delayed PIX_REQ.
REQ-010 VGA_CLK SHALL equal CLOCK_25, so pins are stable at VGA_CLK falling edge.
REQ-011 PRINT SHALL be registered and high for the whole of line PRINT_LINE (800 cycles); it falls at v=PRINT_LINE+1, h=0, so its falling edge strictly precedes the first BLANK_N rise of the next frame.
REQ-012 FRAME_CNT SHALL increment by 1 when both counters wrap together, and wrap 65535->0.
REQ-013 Only free-running operation is defined, with no stall or back-pressure; PIX_RGB is ignored when the delayed PIX_REQ is low.

Reset
REQ-014 Asserting RESET_N low SHALL asynchronously clear h, v, FRAME_CNT, PRINT, VGA_R/G/B and pipeline BLANK_N to 0, and set pipeline HS and VS to 1.
REQ-015 After release, the first rising edge SHALL start counting at h=0, v=0, and pipeline contents SHALL be treated as blank.
REQ-016 Reset asserted mid-frame SHALL abort the frame with no partial PRINT pulse or FRAME_CNT increment.

Structure
REQ-017 The timing parameters, derived H_TOTAL/V_TOTAL and counter widths SHALL live in shared package vga_pkg, for reuse by the pixel source and test bench.
REQ-018 A single sub-module vga_counter SHALL hold the h/v counters and wrap logic; decode, pipeline and PRINT logic stay in vga_timing_gen.

Verification
REQ-019 Reset release, then 800 clocks -> VGA_HS low exactly 96 cycles, falling 658 cycles after release (656+2).
REQ-020 One full frame -> VGA_VS low exactly 1600 cycles; 480 BLANK_N high pulses of 640 cycles each; frame length 420000 cycles.
REQ-021 PIX_RGB driven as {PIX_X[7:0], PIX_Y[7:0], 8'hA5} -> pixel (x=5, y=7) captured at VGA_CLK falling edge reads R=5, G=7, B=A5; blanking intervals read all zero.
REQ-022 PRINT high 800 cycles starting at v=522 -> fall, then next BLANK_N rise occurs 1602 cycles later; FRAME_CNT increments once per 420000 cycles.
REQ-023 RESET_N pulsed low at v=300 -> outputs return to reset values immediately; after release no PRINT until v reaches 522 of the restarted frame.
REQ-024 Run 30 frames with the capture bench -> 30 BMP files, each containing 640x480 pixels matching the programmed pattern.
